// File: rtl/ika87ad_busmem_pkg.sv
// Shared types for the IKA87AD external-bus memory responder.
// Optional error detection is enabled by defining IKA87AD_BUSMEM_ERRDET_EN.
package ika87ad_busmem_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RD_WAIT   = 2'd1,
      RD_HOLD   = 2'd2,
      WR_ACTIVE = 2'd3
   } busmem_state_t;

   typedef enum logic [1:0] {
      REG_ROM  = 2'd0,
      REG_RAM  = 2'd1,
      REG_FIX  = 2'd2,
      REG_NONE = 2'd3
   } region_t;

   localparam int ERR_OVERLAP = 0;
   localparam int ERR_ILLWR   = 1;

endpackage

// File: rtl/ika87ad_busmem_decode.sv
// Combinational region decoder: ROM has priority over RAM, RAM over the
// fixed-value location; anything else is unmapped.
module ika87ad_busmem_decode
   import ika87ad_busmem_pkg::*;
#(
   parameter logic [15:0] ROM_BASE = 16'h0000,
   parameter int          ROM_AW   = 12,
   parameter logic [15:0] RAM_BASE = 16'hFF00,
   parameter int          RAM_AW   = 8,
   parameter logic [15:0] FIX_ADDR = 16'h1401
)
(
   input  logic [15:0]       i_addr,
   output region_t           o_region,
   output logic [ROM_AW-1:0] o_rom_off,
   output logic [RAM_AW-1:0] o_ram_off
);

   // Priority decode of the upper address bits against each region base
   always_comb begin
      o_region = REG_NONE;
      if (i_addr[15:ROM_AW] == ROM_BASE[15:ROM_AW]) begin
         o_region = REG_ROM;
      end else if (i_addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]) begin
         o_region = REG_RAM;
      end else if (i_addr == FIX_ADDR) begin
         o_region = REG_FIX;
      end
   end

   assign o_rom_off = i_addr[ROM_AW-1:0];
   assign o_ram_off = i_addr[RAM_AW-1:0];

endmodule

// File: rtl/ika87ad_busmem.sv
// Registered multi-region bus slave for the IKA87AD core: ROM, RAM, one
// fixed-value location, programmable read wait states and a ROM load port.
// Define IKA87AD_BUSMEM_ERRDET_EN to build the sticky o_ERR detectors.
module ika87ad_busmem
   import ika87ad_busmem_pkg::*;
#(
   parameter logic [15:0] ROM_BASE     = 16'h0000,
   parameter int          ROM_AW       = 12,
   parameter logic [15:0] RAM_BASE     = 16'hFF00,
   parameter int          RAM_AW       = 8,
   parameter logic [15:0] FIX_ADDR     = 16'h1401,
   parameter logic [7:0]  FIX_DATA     = 8'hEE,
   parameter logic [7:0]  OPEN_BUS     = 8'hFF,
   parameter int          WAIT_RD      = 0,
   parameter int          ROM_WRITABLE = 0
)
(
   input  logic              i_EMUCLK,
   input  logic              i_RESET_n,
   input  logic              i_MCUCLK_PCEN,
   input  logic [15:0]       i_A,
   input  logic              i_RD_n,
   input  logic              i_WR_n,
   input  logic [7:0]        i_DO,
   output logic [7:0]        o_DI,
   output logic              o_DI_VALID,
   input  logic              i_LOAD_EN,
   input  logic [ROM_AW-1:0] i_LOAD_ADDR,
   input  logic [7:0]        i_LOAD_DATA,
   output logic [1:0]        o_ERR
);

   localparam int ROM_SIZE = 1 << ROM_AW;
   localparam int RAM_SIZE = 1 << RAM_AW;

   logic [7:0] rom_mem [0:ROM_SIZE-1];
   logic [7:0] ram_mem [0:RAM_SIZE-1];

   busmem_state_t state_q, state_d;
   logic [15:0]   rd_addr_q, rd_addr_d;
   logic [15:0]   wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    di_q, di_d;
   logic          valid_q, valid_d;

   logic [15:0]       rd_sel_addr;
   region_t           rd_region;
   logic [ROM_AW-1:0] rd_rom_off;
   logic [RAM_AW-1:0] rd_ram_off;
   logic [7:0]        rd_data;

   region_t           wr_region;
   logic [ROM_AW-1:0] wr_rom_off;
   logic [RAM_AW-1:0] wr_ram_off;

   logic rd_start;
   logic commit;
   logic commit_ram;
   logic commit_rom;

   // A read begins from IDLE or WR_ACTIVE on the live address; once in
   // progress the latched address is used so later bus changes are ignored.
   assign rd_sel_addr = ((state_q == IDLE) || (state_q == WR_ACTIVE)) ? i_A : rd_addr_q;

   ika87ad_busmem_decode #(
      .ROM_BASE (ROM_BASE),
      .ROM_AW   (ROM_AW),
      .RAM_BASE (RAM_BASE),
      .RAM_AW   (RAM_AW),
      .FIX_ADDR (FIX_ADDR)
   ) u_dec_rd (
      .i_addr    (rd_sel_addr),
      .o_region  (rd_region),
      .o_rom_off (rd_rom_off),
      .o_ram_off (rd_ram_off)
   );

   ika87ad_busmem_decode #(
      .ROM_BASE (ROM_BASE),
      .ROM_AW   (ROM_AW),
      .RAM_BASE (RAM_BASE),
      .RAM_AW   (RAM_AW),
      .FIX_ADDR (FIX_ADDR)
   ) u_dec_wr (
      .i_addr    (wr_addr_q),
      .o_region  (wr_region),
      .o_rom_off (wr_rom_off),
      .o_ram_off (wr_ram_off)
   );

   // Read data mux; memory reads are asynchronous so the value lands in di_q on the same edge
   always_comb begin
      rd_data = OPEN_BUS;
      case (rd_region)
         REG_ROM: rd_data = rom_mem[rd_rom_off];
         REG_RAM: rd_data = ram_mem[rd_ram_off];
         REG_FIX: rd_data = FIX_DATA;
         default: rd_data = OPEN_BUS;
      endcase
   end

   // Next-state and output logic for the bus FSM
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      cnt_d     = cnt_q;
      di_d      = di_q;
      valid_d   = valid_q;
      rd_start  = 1'b0;
      commit    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!i_RD_n) begin
               rd_start = 1'b1;
            end else if (!i_WR_n) begin
               state_d   = WR_ACTIVE;
               wr_addr_d = i_A;
               wr_data_d = i_DO;
            end
         end
         WR_ACTIVE: begin
            if (!i_RD_n) begin
               // A read overlapping an open write wins; the write is abandoned
               rd_start = 1'b1;
            end else if (!i_WR_n) begin
               wr_addr_d = i_A;
               wr_data_d = i_DO;
            end else begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            if (i_RD_n) begin
               // Read strobe withdrawn before data was ready: abandon quietly
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (i_MCUCLK_PCEN) begin
               if (cnt_q == 4'd1) begin
                  di_d    = rd_data;
                  valid_d = 1'b1;
                  cnt_d   = 4'd0;
                  state_d = RD_HOLD;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         RD_HOLD: begin
            if (i_RD_n) begin
               di_d    = OPEN_BUS;
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_start) begin
         rd_addr_d = i_A;
         if (WAIT_RD == 0) begin
            di_d    = rd_data;
            valid_d = 1'b1;
            state_d = RD_HOLD;
         end else begin
            cnt_d   = 4'(WAIT_RD);
            state_d = RD_WAIT;
         end
      end
   end

   assign commit_ram = commit && (wr_region == REG_RAM);
   assign commit_rom = commit && (wr_region == REG_ROM) && (ROM_WRITABLE != 0);

   // FSM and datapath registers with asynchronous active-low reset
   always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         state_q   <= IDLE;
         rd_addr_q <= 16'h0000;
         wr_addr_q <= 16'h0000;
         wr_data_q <= 8'h00;
         cnt_q     <= 4'd0;
         di_q      <= OPEN_BUS;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         cnt_q     <= cnt_d;
         di_q      <= di_d;
         valid_q   <= valid_d;
      end
   end

   // RAM array: written only on a committed CPU write, never cleared
   always_ff @(posedge i_EMUCLK) begin
      if (commit_ram) begin
         ram_mem[wr_ram_off] <= wr_data_q;
      end
   end

   // ROM array: CPU writes when allowed, load port last so it wins a collision
   always_ff @(posedge i_EMUCLK) begin
      if (commit_rom) begin
         rom_mem[wr_rom_off] <= wr_data_q;
      end
      if (i_LOAD_EN) begin
         rom_mem[i_LOAD_ADDR] <= i_LOAD_DATA;
      end
   end

   assign o_DI       = di_q;
   assign o_DI_VALID = valid_q;

`ifdef IKA87AD_BUSMEM_ERRDET_EN
   logic [1:0] err_q, err_d;

   // Sticky error flags: strobe overlap and writes that could not land anywhere
   always_comb begin
      err_d = err_q;
      if (!i_RD_n && !i_WR_n) begin
         err_d[ERR_OVERLAP] = 1'b1;
      end
      if (commit && !commit_ram && !commit_rom) begin
         err_d[ERR_ILLWR] = 1'b1;
      end
   end

   // Error flag register, cleared only by reset
   always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         err_q <= 2'b00;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_ERR = err_q;
`else
   assign o_ERR = 2'b00;
`endif

endmodule

// File: tb/tb_ika87ad_busmem.sv
// Testbench for ika87ad_busmem: two instances share one bus, one with no
// read wait states and one with WAIT_RD=3. Read data of the zero-wait
// instance is checked by a scoreboard monitor. Honours IKA87AD_BUSMEM_ERRDET_EN.
module tb_ika87ad_busmem;

   typedef enum int {OP_LOAD, OP_WRITE, OP_READ} op_t;

`ifdef IKA87AD_BUSMEM_ERRDET_EN
   localparam bit ERRDET = 1'b1;
`else
   localparam bit ERRDET = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        pcen;
   logic [15:0] addr;
   logic        rd_n;
   logic        wr_n;
   logic [7:0]  dout;
   logic        load_en;
   logic [11:0] load_addr;
   logic [7:0]  load_data;

   logic [7:0]  di0, di3;
   logic        valid0, valid3;
   logic [1:0]  err0, err3;

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] exp_q [$];

   ika87ad_busmem #(.WAIT_RD(0)) dut0 (
      .i_EMUCLK      (clk),
      .i_RESET_n     (rst_n),
      .i_MCUCLK_PCEN (pcen),
      .i_A           (addr),
      .i_RD_n        (rd_n),
      .i_WR_n        (wr_n),
      .i_DO          (dout),
      .o_DI          (di0),
      .o_DI_VALID    (valid0),
      .i_LOAD_EN     (load_en),
      .i_LOAD_ADDR   (load_addr),
      .i_LOAD_DATA   (load_data),
      .o_ERR         (err0)
   );

   ika87ad_busmem #(.WAIT_RD(3)) dut3 (
      .i_EMUCLK      (clk),
      .i_RESET_n     (rst_n),
      .i_MCUCLK_PCEN (pcen),
      .i_A           (addr),
      .i_RD_n        (rd_n),
      .i_WR_n        (wr_n),
      .i_DO          (dout),
      .o_DI          (di3),
      .o_DI_VALID    (valid3),
      .i_LOAD_EN     (load_en),
      .i_LOAD_ADDR   (load_addr),
      .i_LOAD_DATA   (load_data),
      .o_ERR         (err3)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // CPU clock enable: one EMUCLK cycle high out of every four
   initial begin
      logic [1:0] div;
      div  = 2'd0;
      pcen = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         div  = div + 2'd1;
         pcen = (div == 2'd0);
      end
   end

   // Global time limit so the bench cannot hang
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every new read result from dut0 pops one expectation
   initial begin
      logic prev;
      logic [7:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (valid0 && !prev) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("[TB] FAIL unexpected read: got %02h, expected no read", di0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("read data", di0, e);
            end
         end
         prev = valid0;
      end
   end

   task automatic applyStimulus(input op_t op, input logic [15:0] a, input logic [7:0] d);
      case (op)
         OP_LOAD: begin
            @(posedge clk); #1;
            load_en   = 1'b1;
            load_addr = a[11:0];
            load_data = d;
            @(posedge clk); #1;
            load_en   = 1'b0;
         end
         OP_WRITE: begin
            @(posedge clk); #1;
            addr = a;
            dout = d;
            wr_n = 1'b0;
            @(posedge clk); #1;
            wr_n = 1'b1;
            @(posedge clk); #1;
         end
         default: begin
            @(posedge clk); #1;
            addr = a;
            rd_n = 1'b0;
            exp_q.push_back(d);
            @(posedge clk); #1;
            rd_n = 1'b1;
            @(posedge clk); #1;
         end
      endcase
   endtask

   initial begin
      int pcen_seen;
      logic early;
      logic p;

      rst_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; addr = 16'h0000; dout = 8'h00;
      load_en = 1'b0; load_addr = 12'h000; load_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset di", di0, 8'hFF);
      checkOutput("reset valid", {7'b0, valid0}, 8'h00);
      checkOutput("reset err", {6'b0, err0}, 8'h00);
      checkOutput("reset di wait3", di3, 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: zero-wait ROM read latency and open bus after release
      $display("[TB] test 1: ROM read latency");
      applyStimulus(OP_LOAD, 16'h0000, 8'h54);
      @(posedge clk); #1;
      addr = 16'h0000;
      rd_n = 1'b0;
      exp_q.push_back(8'h54);
      @(negedge clk);
      checkOutput("t1 valid before edge", {7'b0, valid0}, 8'h00);
      checkOutput("t1 di before edge", di0, 8'hFF);
      @(negedge clk);
      checkOutput("t1 valid after edge", {7'b0, valid0}, 8'h01);
      rd_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("t1 di after release", di0, 8'hFF);
      checkOutput("t1 valid after release", {7'b0, valid0}, 8'h00);

      // Test 6: address changes during RD_HOLD are ignored
      $display("[TB] test 6: hold ignores address changes");
      applyStimulus(OP_LOAD, 16'h0001, 8'h99);
      @(posedge clk); #1;
      addr = 16'h0000;
      rd_n = 1'b0;
      exp_q.push_back(8'h54);
      @(posedge clk); #1;
      addr = 16'h0001;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checkOutput("t6 di frozen", di0, 8'h54);
      end
      rd_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("t6 di after release", di0, 8'hFF);

      // Test 2: RAM write/readback, fixed location, unmapped address
      $display("[TB] test 2: RAM, fixed and unmapped reads");
      applyStimulus(OP_WRITE, 16'hFF10, 8'hA5);
      applyStimulus(OP_READ, 16'hFF10, 8'hA5);
      applyStimulus(OP_READ, 16'h1401, 8'hEE);
      applyStimulus(OP_READ, 16'h8000, 8'hFF);

      // Test 3: WAIT_RD=3 instance becomes valid on the 3rd PCEN
      $display("[TB] test 3: read wait states");
      applyStimulus(OP_LOAD, 16'h0020, 8'h3C);
      @(posedge clk); #1;
      addr = 16'h0020;
      rd_n = 1'b0;
      exp_q.push_back(8'h3C);
      @(posedge clk); #1;
      pcen_seen = 0;
      early     = 1'b0;
      for (int k = 0; k < 40 && pcen_seen < 3; k++) begin
         @(negedge clk);
         p = pcen;
         @(posedge clk); #1;
         if (p) pcen_seen++;
         if (pcen_seen < 3 && (valid3 || di3 !== 8'hFF)) early = 1'b1;
      end
      checkOutput("t3 pcen count reached", 8'(pcen_seen), 8'd3);
      checkOutput("t3 no early data", {7'b0, early}, 8'h00);
      checkOutput("t3 valid at 3rd pcen", {7'b0, valid3}, 8'h01);
      checkOutput("t3 data at 3rd pcen", di3, 8'h3C);
      rd_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("t3 di after release", di3, 8'hFF);

      // Test 4: illegal ROM write and strobe overlap
      $display("[TB] test 4: error flags and overlap");
      applyStimulus(OP_LOAD, 16'h0010, 8'h66);
      applyStimulus(OP_WRITE, 16'h0010, 8'h12);
      checkOutput("t4 err after rom write", {6'b0, err0}, ERRDET ? 8'h02 : 8'h00);
      applyStimulus(OP_READ, 16'h0010, 8'h66);
      applyStimulus(OP_WRITE, 16'hFF30, 8'h5A);
      @(posedge clk); #1;
      addr = 16'hFF30;
      dout = 8'h11;
      wr_n = 1'b0;
      exp_q.push_back(8'h5A);
      @(posedge clk); #1;
      rd_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("t4 overlap read taken", {7'b0, valid0}, 8'h01);
      checkOutput("t4 err after overlap", {6'b0, err0}, ERRDET ? 8'h03 : 8'h00);
      rd_n = 1'b1;
      wr_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(OP_READ, 16'hFF30, 8'h5A);

      // Test 5: asynchronous reset while a write is open
      $display("[TB] test 5: reset during write");
      applyStimulus(OP_WRITE, 16'hFF20, 8'h31);
      @(posedge clk); #1;
      addr = 16'hFF20;
      dout = 8'h77;
      wr_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5 di in reset", di0, 8'hFF);
      checkOutput("t5 valid in reset", {7'b0, valid0}, 8'h00);
      checkOutput("t5 err in reset", {6'b0, err0}, 8'h00);
      wr_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(OP_READ, 16'hFF20, 8'h31);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard drained", 8'(exp_q.size()), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
